// File: rtl/restoring_divider_seq_if.sv
// ---------------------------------------------------------------------------
// restoring_divider_seq_if
//   Request/response bundle for the sequential restoring divider.
//
//   Request  (master -> slave): start, dividend, divisor
//   Response (slave -> master): busy, done, quotient, remainder
//                               div_by_zero (only with RDIV_DIVZERO_DETECT_EN)
//
//   master : the client that issues divides (testbench / surrounding logic)
//   slave  : the divider itself
//
//   Build option: RDIV_DIVZERO_DETECT_EN adds the div_by_zero response flag.
// ---------------------------------------------------------------------------
interface restoring_divider_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
`ifdef RDIV_DIVZERO_DETECT_EN
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder
    );
`endif
endinterface

// File: rtl/restoring_divider_seq.sv
// ---------------------------------------------------------------------------
// restoring_divider_seq
//   Sequential unsigned restoring divider. One quotient bit is produced per
//   clock from a WIDTH+1-bit trial subtraction, so a divide takes WIDTH
//   iterations. Handshake is start / busy / done.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : restoring_divider_seq_if.slave
//              start     - request, sampled only while busy=0 (IDLE or DONE)
//              dividend  - numerator, captured on the accepting edge
//              divisor   - denominator, captured on the accepting edge
//              busy      - high while iterating
//              done      - one-cycle pulse, quotient/remainder valid
//              quotient  - held until the next completion
//              remainder - held until the next completion
//              div_by_zero (RDIV_DIVZERO_DETECT_EN only) - held with results
//
//   Timing: start sampled on edge E -> done high in the cycle after E+WIDTH.
//   A start during the DONE cycle is accepted directly (one result per
//   WIDTH+1 cycles back-to-back).
//
//   Build option RDIV_DIVZERO_DETECT_EN: a zero divisor finishes on the first
//   edge after acceptance with quotient=all ones, remainder=dividend and
//   div_by_zero=1. Without it a zero divisor simply runs the normal WIDTH
//   steps, which yields the same quotient/remainder with no flag.
// ---------------------------------------------------------------------------

// One restoring step: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor, keep the difference if it did not borrow.
module restoring_divider_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] prem_in,   // partial remainder, always < divisor
    input  logic             dvd_msb,   // next dividend bit to bring down
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] prem_out,
    output logic             qbit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Since prem_in < divisor, the shifted value is < 2*divisor and needs
    // WIDTH+1 bits; the difference, when kept, is again < divisor, so the
    // stored remainder fits back into WIDTH bits.
    assign shifted  = {prem_in, dvd_msb};
    assign diff     = shifted - {1'b0, divisor};
    assign qbit     = ~diff[WIDTH];   // MSB set means the subtract borrowed
    assign prem_out = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

module restoring_divider_seq #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    restoring_divider_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_n;

    // dvd_q doubles as the quotient accumulator: dividend bits leave at the
    // top while quotient bits enter at the bottom.
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] prem_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    logic [WIDTH-1:0] prem_nx;
    logic             qbit;

    logic load, step, last, busy_c, done_c;
`ifdef RDIV_DIVZERO_DETECT_EN
    logic zfin;
    logic dz_q;
`endif

    restoring_divider_step #(.WIDTH(WIDTH)) u_step (
        .prem_in  (prem_q),
        .dvd_msb  (dvd_q[WIDTH-1]),
        .divisor  (dvsr_q),
        .prem_out (prem_nx),
        .qbit     (qbit)
    );

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // -----------------------------------------------------------------------
    // FSM next state and control strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
`ifdef RDIV_DIVZERO_DETECT_EN
        zfin    = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = S_CALC;
                end
            end
            S_CALC: begin
                busy_c = 1'b1;
`ifdef RDIV_DIVZERO_DETECT_EN
                // Zero divisor: no iterations, finish on this first edge.
                if (dvsr_q == '0) begin
                    zfin    = 1'b1;
                    state_n = S_DONE;
                end else
`endif
                begin
                    step = 1'b1;
                    // cnt_q counts remaining steps; 1 means this is the last.
                    if (cnt_q == CW'(1)) begin
                        last    = 1'b1;
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_c = 1'b1;
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = S_CALC;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Iteration datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q  <= '0;
            dvsr_q <= '0;
            prem_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            dvd_q  <= bus.dividend;
            dvsr_q <= bus.divisor;
            prem_q <= '0;
            cnt_q  <= CW'(WIDTH);
        end else if (step) begin
            dvd_q  <= {dvd_q[WIDTH-2:0], qbit};
            prem_q <= prem_nx;
            cnt_q  <= cnt_q - CW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Result registers: only move on a completion edge
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= '0;
            rem_q  <= '0;
`ifdef RDIV_DIVZERO_DETECT_EN
            dz_q   <= 1'b0;
`endif
        end else begin
            if (step && last) begin
                quot_q <= {dvd_q[WIDTH-2:0], qbit};
                rem_q  <= prem_nx;
`ifdef RDIV_DIVZERO_DETECT_EN
                dz_q   <= 1'b0;
`endif
            end
`ifdef RDIV_DIVZERO_DETECT_EN
            // No step has run, so dvd_q still holds the captured dividend.
            if (zfin) begin
                quot_q <= '1;
                rem_q  <= dvd_q;
                dz_q   <= 1'b1;
            end
`endif
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
`ifdef RDIV_DIVZERO_DETECT_EN
    assign bus.div_by_zero = dz_q;
`endif

endmodule

// File: tb/tb_restoring_divider_seq.sv
// ---------------------------------------------------------------------------
// tb_restoring_divider_seq
//   Self-checking bench for restoring_divider_seq at WIDTH=8. Expected
//   results come from plain integer division; expected latency from the
//   handshake rules. Works with and without RDIV_DIVZERO_DETECT_EN.
// ---------------------------------------------------------------------------
module tb_restoring_divider_seq;
    localparam int W = 8;
`ifdef RDIV_DIVZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    // Values the result outputs are expected to be holding right now.
    logic [W-1:0] exp_q = '0;
    logic [W-1:0] exp_r = '0;

    restoring_divider_seq_if #(.WIDTH(W)) bus ();

    restoring_divider_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        int ai, bi;
        ai = a; bi = b;
        if (bi == 0) return '1;
        return W'(ai / bi);
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        int ai, bi;
        ai = a; bi = b;
        if (bi == 0) return a;
        return W'(ai % bi);
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b);
        if (DZ_EN && b == '0) return 1;
        return W;
    endfunction

    // Presents a request and holds start across one rising edge. With
    // now=0 it first moves to the next falling edge; with now=1 it drives
    // immediately (used from the DONE cycle for back-to-back issue).
    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit now);
        if (!now) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Called right after the accepting edge. Waits (bounded) for done and
    // checks latency, busy length, held results, and the new results.
    // Returns at the falling edge inside the done cycle.
    task automatic wait_done(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int n, nbusy;
        bit moved, seen;
        logic [W-1:0] eq, er;
        n = 0; nbusy = 0; moved = 0; seen = 0;
        eq = ref_q(a, b);
        er = ref_r(a, b);
        while (n < 4 * W && !seen) begin
            @(negedge clk);
            n++;
            if (bus.busy === 1'b1) nbusy++;
            if (bus.done === 1'b1) seen = 1;
            else if (bus.quotient !== exp_q || bus.remainder !== exp_r) moved = 1;
        end
        chk({tag, ".lat"},  n,     ref_lat(b) + 1);
        chk({tag, ".busy"}, nbusy, ref_lat(b));
        chk({tag, ".held"}, 32'(moved), 0);
        chk({tag, ".q"},    bus.quotient,  eq);
        chk({tag, ".r"},    bus.remainder, er);
`ifdef RDIV_DIVZERO_DETECT_EN
        chk({tag, ".dz"},   bus.div_by_zero, (b == '0) ? 1 : 0);
`endif
        exp_q = eq;
        exp_r = er;
    endtask

    initial begin
        int pulses;
        bit moved;
        logic [W-1:0] a, b;

        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.q",    bus.quotient, 0);
        chk("rst.r",    bus.remainder, 0);
`ifdef RDIV_DIVZERO_DETECT_EN
        chk("rst.dz",   bus.div_by_zero, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic divide
        start_div(8'd100, 8'd7, 0);
        wait_done(8'd100, 8'd7, "d100_7");

        // Back-to-back: second start presented in the DONE cycle
        start_div(8'd255, 8'd1, 0);
        wait_done(8'd255, 8'd1, "d255_1");
        start_div(8'd5, 8'd9, 1);
        wait_done(8'd5, 8'd9, "b2b5_9");

        // Start toggling and operand churn while busy must be ignored
        start_div(8'hC8, 8'h0D, 0);
        moved = 0;
        for (int n = 1; n <= W; n++) begin
            @(negedge clk);
            if (bus.quotient !== exp_q || bus.remainder !== exp_r) moved = 1;
            bus.start    = ~bus.start;
            bus.dividend = W'($urandom);
            bus.divisor  = W'($urandom);
        end
        bus.start = 1'b0;
        chk("ign.held", 32'(moved), 0);
        @(negedge clk);
        chk("ign.done", bus.done, 1);
        chk("ign.q", bus.quotient, 15);
        chk("ign.r", bus.remainder, 5);
        exp_q = 8'd15; exp_r = 8'd5;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        chk("ign.extra_done", pulses, 0);

        // Divide by zero
        start_div(8'h5A, 8'h00, 0);
        wait_done(8'h5A, 8'h00, "dz5A");

        // Reset in the middle of a divide
        start_div(8'd200, 8'd3, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst.busy", bus.busy, 0);
        chk("mrst.done", bus.done, 0);
        chk("mrst.q",    bus.quotient, 0);
        chk("mrst.r",    bus.remainder, 0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) pulses++;
        end
        chk("mrst.quiet", pulses, 0);
        rst_n = 1'b1;
        exp_q = '0; exp_r = '0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0) pulses++;
        end
        chk("mrst.no_done", pulses, 0);
        start_div(8'd9, 8'd3, 0);
        wait_done(8'd9, 8'd3, "post_rst");

        // Boundary operands
        start_div(8'd0,   8'd1,   0); wait_done(8'd0,   8'd1,   "e0_1");
        start_div(8'd255, 8'd255, 0); wait_done(8'd255, 8'd255, "e255_255");
        start_div(8'd254, 8'd255, 0); wait_done(8'd254, 8'd255, "e254_255");
        start_div(8'd0,   8'd0,   0); wait_done(8'd0,   8'd0,   "e0_0");
        start_div(8'd255, 8'd0,   1); wait_done(8'd255, 8'd0,   "e255_0");
        start_div(8'd128, 8'd2,   1); wait_done(8'd128, 8'd2,   "e128_2");

        // Randomized operands, mixing idle gaps and back-to-back issue
        for (int i = 0; i < 2500; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            start_div(a, b, ($urandom_range(0, 3) == 0));
            wait_done(a, b, "rnd");
        end

        @(negedge clk);
        chk("final.idle", {bus.busy, bus.done}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
